cic_decimator: RTL and testbench
================================

# cic_decimator

Dual-channel (I/Q) pipelined Hogenauer CIC decimator that sits directly downstream of the CORDIC downconverter. It consumes the downconverter's rounded x/y outputs and aux/valid strobe. It reduces the sample rate by a run-time rate R (1..2^RW-1) with N integrator/comb stages (differential delay M=1). Output is scaled by a run-time right shift, then rounded and saturated.

## Interface
- IW, 13, input sample width (matches downconverter output width)
- OW, 16, output sample width
- NSTAGES, 3, integrator and comb stage count N
- RW, 10, width of rate input; max R = 2^RW-1
- SW, 6, width of shift input
- WW, IW+NSTAGES*RW (43), internal width, full bit growth at max R
- i_clk  in  1  clock
- i_reset_n  in  1  synchronous active-low reset
- i_ce  in  1  global clock enable; low freezes all state
- i_xval  in  IW  signed I sample
- i_yval  in  IW  signed Q sample
- i_aux  in  1  input sample valid; sample accepted when i_ce && i_aux
- i_rate  in  RW  decimation rate R; 0 treated as 1
- i_shift  in  SW  output right-shift, legal 0..WW-1
- o_xval  out  OW  signed decimated I
- o_yval  out  OW  signed decimated Q
- o_aux  out  1  one-cycle output valid strobe

## Operation
- Accept: sign-extend i_xval/i_yval to WW. N cascaded registered integrators per channel update only on accepted samples: int1 += x, intk += int(k-1) (previous register value). All arithmetic wraps modulo 2^WW; wrap is intentional and required.
- Rate latch: rate_q and shift_q are loaded from i_rate/i_shift on reset and at each block boundary. Changes to i_rate/i_shift mid-block take effect for the next block only.
- Decimation counter cnt: counts accepted samples 0..rate_q-1.
  - On the accepted sample with cnt == rate_q-1, cnt returns to 0, rate_q/shift_q reload, and dec_stb is set for one enabled cycle.
  - With rate_q == 1, every accepted sample closes a block.
- Comb section: on dec_stb, comb1 input = intN. Each comb stage k computes y = in - dly_k, then dly_k <= in, registered. Valid travels through N comb registers; combs advance only when their own valid is present and i_ce is high.
- Output stage: v = comb_N + (shift_q>0 ? 2^(shift_q-1) : 0), then arithmetic shift right by shift_q (round half up). Saturate to [-2^(OW-1), 2^(OW-1)-1], register to o_xval/o_yval, and pulse o_aux.
- shift_q travels with its block through the comb pipeline, so a block is scaled by the shift latched at its own start.
- DC gain before shift = R^N.

## Timing
- Reset (i_reset_n low at posedge): integrators, comb data/delay registers, cnt, dec_stb and valid pipe are cleared. o_xval=0, o_yval=0, o_aux=0 from the next cycle. rate_q<=i_rate, shift_q<=i_shift. A partial block is discarded.
- Latency: with i_ce held high, o_aux asserts N+2 cycles after the posedge that accepts the block-closing sample (1 dec_stb + N comb + 1 output).
- i_ce low: all registers, including o_aux, hold; latency extends by the number of low cycles. o_aux holds for exactly one enabled cycle per output.
- Throughput: one accepted sample per cycle sustained, including R=1 (one output per cycle after pipeline fill).
- o_xval/o_yval hold their last value between strobes.
- Startup transient: the first N outputs after reset are transient. Steady-state data begins at output N+1.

## Test plan
- DC gain: x=+1000, y=-1000 every cycle, R=16, shift=12 (gain 4096) -> from the 4th output onward o_xval=1000, o_yval=-1000, o_aux once per 16 cycles, first strobe 5 cycles after the 16th sample.
- Saturation: x=4095, y=-4096 constant, R=1023, shift=0 -> steady o_xval=32767, o_yval=-32768.
- Rounding: R=2, shift=4 (gain 8), x=3, y=-3 -> steady o_xval=2 (24/16=1.5 rounds up), o_yval=-1 (-1.5 rounds up).
- Gating: i_aux every other cycle, R=4 -> o_aux every 8 cycles. Then i_ce low 5 cycles mid-block -> that strobe is delayed exactly 5 cycles, values unchanged vs ungated run.
- Rate change: R=8, i_rate changed to 4 after 3 samples of a block -> that block closes after 8 samples, subsequent blocks every 4 samples.
- Reset mid-block: reset after 5 of 8 samples -> outputs 0 and o_aux 0 next cycle. The next strobe comes only after 8 new samples, and DC steady value is restored after N+1 outputs.

Source files
------------

// File: rtl/cic_decimator.sv
// Dual-channel (I/Q) Hogenauer CIC decimator: N integrators at the input rate, N combs at the
// decimated rate, then round-half-up right shift and saturation to OW bits.
module cic_decimator #(
    parameter int IW      = 13,
    parameter int OW      = 16,
    parameter int NSTAGES = 3,
    parameter int RW      = 10,
    parameter int SW      = 6,
    parameter int WW      = IW + NSTAGES * RW
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_ce,
    input  logic signed [IW-1:0] i_xval,
    input  logic signed [IW-1:0] i_yval,
    input  logic                 i_aux,
    input  logic [RW-1:0]        i_rate,
    input  logic [SW-1:0]        i_shift,
    output logic signed [OW-1:0] o_xval,
    output logic signed [OW-1:0] o_yval,
    output logic                 o_aux
);

    localparam logic signed [WW:0] SAT_HI = (WW+1)'(2 ** (OW - 1) - 1);
    localparam logic signed [WW:0] SAT_LO = ~SAT_HI;

    logic                  accept;
    logic                  blk_end;
    logic [RW-1:0]         rate_lat_reg;
    logic [RW-1:0]         cnt_reg;
    logic [RW-1:0]         last_cnt;
    logic [SW-1:0]         shift_lat_reg;
    logic [SW-1:0]         dec_shift_reg;
    logic                  dec_stb_reg;
    logic [NSTAGES:0]      vld_reg;
    logic [SW-1:0]         shift_pipe_reg [NSTAGES+1];
    logic                  aux_reg;
    logic [1:0][IW-1:0]    ch_in;
    logic [1:0][OW-1:0]    ch_out;

    assign accept   = i_ce && i_aux;
    assign last_cnt = (rate_lat_reg == '0) ? '0 : rate_lat_reg - RW'(1);
    assign blk_end  = accept && (cnt_reg == last_cnt);

    assign ch_in[0] = i_xval;
    assign ch_in[1] = i_yval;
    assign o_xval   = ch_out[0];
    assign o_yval   = ch_out[1];
    assign o_aux    = aux_reg;

    // Block control; the shift of each block rides alongside its valid bit down the comb pipe.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            rate_lat_reg  <= i_rate;
            shift_lat_reg <= i_shift;
            cnt_reg       <= '0;
            dec_stb_reg   <= 1'b0;
            dec_shift_reg <= '0;
            vld_reg       <= '0;
            aux_reg       <= 1'b0;
            for (int k = 0; k <= NSTAGES; k++) begin
                shift_pipe_reg[k] <= '0;
            end
        end else if (i_ce) begin
            dec_stb_reg <= blk_end;
            if (blk_end) begin
                cnt_reg       <= '0;
                dec_shift_reg <= shift_lat_reg;
                rate_lat_reg  <= i_rate;
                shift_lat_reg <= i_shift;
            end else if (accept) begin
                cnt_reg <= cnt_reg + RW'(1);
            end
            vld_reg <= {vld_reg[NSTAGES-1:0], dec_stb_reg};
            if (dec_stb_reg) begin
                shift_pipe_reg[0] <= dec_shift_reg;
            end
            for (int k = 1; k <= NSTAGES; k++) begin
                if (vld_reg[k-1]) begin
                    shift_pipe_reg[k] <= shift_pipe_reg[k-1];
                end
            end
            aux_reg <= vld_reg[NSTAGES];
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        logic [NSTAGES:0][WW-1:0] int_chain;
        logic [NSTAGES:0][WW-1:0] comb_chain;
        logic [WW-1:0]            smp_reg;
        logic [SW-1:0]            out_shift;
        logic signed [WW:0]       rnd_bias;
        logic signed [WW:0]       rnd_sum;
        logic signed [WW:0]       shifted;
        logic signed [OW-1:0]     sat_val;
        logic signed [OW-1:0]     out_reg;

        assign int_chain[0] = {{(WW-IW){ch_in[gi][IW-1]}}, ch_in[gi]};

        // Integrators wrap modulo 2^WW; the combs undo the wrap exactly.
        for (genvar gk = 0; gk < NSTAGES; gk++) begin : g_int
            logic [WW-1:0] acc_reg;
            always_ff @(posedge i_clk) begin
                if (!i_reset_n) begin
                    acc_reg <= '0;
                end else if (accept) begin
                    acc_reg <= acc_reg + int_chain[gk];
                end
            end
            assign int_chain[gk+1] = acc_reg;
        end

        always_ff @(posedge i_clk) begin
            if (!i_reset_n) begin
                smp_reg <= '0;
            end else if (i_ce && dec_stb_reg) begin
                smp_reg <= int_chain[NSTAGES];
            end
        end
        assign comb_chain[0] = smp_reg;

        for (genvar gk = 0; gk < NSTAGES; gk++) begin : g_comb
            logic [WW-1:0] dly_reg;
            logic [WW-1:0] diff_reg;
            always_ff @(posedge i_clk) begin
                if (!i_reset_n) begin
                    dly_reg  <= '0;
                    diff_reg <= '0;
                end else if (i_ce && vld_reg[gk]) begin
                    dly_reg  <= comb_chain[gk];
                    diff_reg <= comb_chain[gk] - dly_reg;
                end
            end
            assign comb_chain[gk+1] = diff_reg;
        end

        // One guard bit so the rounding bias cannot wrap a near-full-scale comb result.
        assign out_shift = shift_pipe_reg[NSTAGES];
        assign rnd_bias  = (out_shift == '0) ? '0 : ((WW+1)'(1) << (out_shift - SW'(1)));
        assign rnd_sum   = $signed({comb_chain[NSTAGES][WW-1], comb_chain[NSTAGES]}) + rnd_bias;
        assign shifted   = rnd_sum >>> out_shift;

        always_comb begin
            if (shifted > SAT_HI) begin
                sat_val = OW'(SAT_HI);
            end else if (shifted < SAT_LO) begin
                sat_val = OW'(SAT_LO);
            end else begin
                sat_val = shifted[OW-1:0];
            end
        end

        always_ff @(posedge i_clk) begin
            if (!i_reset_n) begin
                out_reg <= '0;
            end else if (i_ce && vld_reg[NSTAGES]) begin
                out_reg <= sat_val;
            end
        end
        assign ch_out[gi] = out_reg;
    end

endmodule

// File: tb/tb_cic_decimator.sv
// Randomized and directed bench for cic_decimator against an input-rate sum / binomial-difference
// reference model that predicts every output value and the enabled cycle of its strobe.
module tb_cic_decimator;
    localparam int IW = 13;
    localparam int OW = 16;
    localparam int NS = 3;
    localparam int RW = 10;
    localparam int SW = 6;
    localparam int WW = IW + NS * RW;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 ce;
    logic                 aux;
    logic signed [IW-1:0] xin;
    logic signed [IW-1:0] yin;
    logic [RW-1:0]        rate;
    logic [SW-1:0]        shift;
    logic signed [OW-1:0] xout;
    logic signed [OW-1:0] yout;
    logic                 aux_out;

    always #5 clk = ~clk;

    cic_decimator dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_ce      (ce),
        .i_xval    (xin),
        .i_yval    (yin),
        .i_aux     (aux),
        .i_rate    (rate),
        .i_shift   (shift),
        .o_xval    (xout),
        .o_yval    (yout),
        .o_aux     (aux_out)
    );

    typedef struct {
        longint edge_n;
        longint x;
        longint y;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [WW-1:0] mi_x [NS];
    logic signed [WW-1:0] mi_y [NS];
    logic signed [WW-1:0] hx [NS+1];
    logic signed [WW-1:0] hy [NS+1];
    int     m_cnt, m_rate, m_shift;
    exp_t   eq [$];
    longint stb_q [$];
    longint ecnt = 0;
    longint cyc = 0;
    longint rst_cyc = 0;
    logic   exp_aux = 1'b0;
    longint cur_x = 0;
    longint cur_y = 0;
    int     en_i, n8, n13;

    task automatic check_eq(input string tag, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // N-th backward difference of the decimated integrator samples, via binomial weights.
    function automatic longint block_out(input logic signed [WW-1:0] h [NS+1], input int sh);
        logic signed [WW-1:0] s;
        logic signed [WW-1:0] term;
        longint t;
        int c;
        s = '0;
        c = 1;
        for (int j = 0; j <= NS; j++) begin
            term = h[j] * c;
            s = (j % 2 == 0) ? s + term : s - term;
            c = c * (NS - j) / (j + 1);
        end
        t = longint'(s);
        if (sh > 0) t += (longint'(1) << (sh - 1));
        t = t >>> sh;
        if (t > (2 ** (OW - 1)) - 1) t = (2 ** (OW - 1)) - 1;
        if (t < -(2 ** (OW - 1))) t = -(2 ** (OW - 1));
        return t;
    endfunction

    function automatic longint gap(input int i);
        if (i + 1 < stb_q.size()) return stb_q[i+1] - stb_q[i];
        return -1;
    endfunction

    task automatic model_edge();
        int eff;
        exp_t e;
        if (!reset_n) begin
            for (int k = 0; k < NS; k++) begin
                mi_x[k] = '0;
                mi_y[k] = '0;
            end
            for (int j = 0; j <= NS; j++) begin
                hx[j] = '0;
                hy[j] = '0;
            end
            m_cnt = 0;
            m_rate = int'(rate);
            m_shift = int'(shift);
            eq.delete();
            exp_aux = 1'b0;
            cur_x = 0;
            cur_y = 0;
            rst_cyc = cyc;
        end else if (ce) begin
            ecnt++;
            if (aux) begin
                for (int k = NS - 1; k >= 1; k--) begin
                    mi_x[k] += mi_x[k-1];
                    mi_y[k] += mi_y[k-1];
                end
                mi_x[0] += xin;
                mi_y[0] += yin;
                eff = (m_rate == 0) ? 1 : m_rate;
                if (m_cnt == eff - 1) begin
                    m_cnt = 0;
                    for (int j = NS; j >= 1; j--) begin
                        hx[j] = hx[j-1];
                        hy[j] = hy[j-1];
                    end
                    hx[0] = mi_x[NS-1];
                    hy[0] = mi_y[NS-1];
                    e.edge_n = ecnt + NS + 2;
                    e.x = block_out(hx, m_shift);
                    e.y = block_out(hy, m_shift);
                    eq.push_back(e);
                    m_rate = int'(rate);
                    m_shift = int'(shift);
                end else begin
                    m_cnt++;
                end
            end
            exp_aux = (eq.size() > 0 && eq[0].edge_n == ecnt);
            if (exp_aux) begin
                cur_x = eq[0].x;
                cur_y = eq[0].y;
                void'(eq.pop_front());
            end
        end
    endtask

    task automatic tick();
        cyc++;
        model_edge();
        @(posedge clk);
        #1;
        check_eq("o_aux", aux_out, exp_aux);
        check_eq("o_xval", xout, cur_x);
        check_eq("o_yval", yout, cur_y);
        if (reset_n && ce && aux_out) stb_q.push_back(cyc);
    endtask

    task automatic do_reset(input int r, input int s);
        reset_n = 1'b0;
        ce = 1'b1;
        aux = 1'b0;
        xin = '0;
        yin = '0;
        rate = RW'(r);
        shift = SW'(s);
        tick();
        reset_n = 1'b1;
        stb_q.delete();
    endtask

    initial begin
        // DC gain: R=16, N=3, shift 12 -> unity
        do_reset(16, 12);
        xin = 13'sd1000;
        yin = -13'sd1000;
        aux = 1'b1;
        repeat (16 * 7) tick();
        check_eq("dc_nstb", stb_q.size() >= 4, 1);
        check_eq("dc_first_latency", stb_q.size() > 0 ? stb_q[0] - rst_cyc : -1, 21);
        check_eq("dc_period", gap(0), 16);
        check_eq("dc_x", xout, 1000);
        check_eq("dc_y", yout, -1000);

        // Saturation
        do_reset(1023, 0);
        xin = 13'sd4095;
        yin = -13'sd4096;
        aux = 1'b1;
        repeat (1023 * 4 + 10) tick();
        check_eq("sat_x", xout, 32767);
        check_eq("sat_y", yout, -32768);

        // Rounding half up: +-1.5
        do_reset(2, 4);
        xin = 13'sd3;
        yin = -13'sd3;
        aux = 1'b1;
        repeat (20) tick();
        check_eq("rnd_x", xout, 2);
        check_eq("rnd_y", yout, -1);

        // Gating: sample every other enabled cycle, then a 5-cycle clock-enable hole
        do_reset(4, 6);
        xin = 13'sd100;
        yin = -13'sd50;
        en_i = 0;
        for (int i = 0; i < 100; i++) begin
            ce = !(i >= 50 && i < 55);
            aux = (en_i % 2 == 0);
            tick();
            if (ce) en_i++;
        end
        ce = 1'b1;
        n8 = 0;
        n13 = 0;
        for (int i = 0; i + 1 < stb_q.size(); i++) begin
            if (gap(i) == 8) n8++;
            else if (gap(i) == 13) n13++;
        end
        check_eq("gate_nstb", stb_q.size() >= 8, 1);
        check_eq("gate_gap13", n13, 1);
        check_eq("gate_gap8", n8, stb_q.size() - 2);

        // Rate change mid-block applies to the next block only
        do_reset(8, 9);
        xin = 13'sd500;
        yin = 13'sd7;
        aux = 1'b1;
        for (int i = 0; i < 60; i++) begin
            rate = (i >= 11) ? RW'(4) : RW'(8);
            tick();
        end
        check_eq("rc_gap0", gap(0), 8);
        check_eq("rc_gap1", gap(1), 4);
        check_eq("rc_gap2", gap(2), 4);

        // Reset mid-block
        do_reset(8, 9);
        xin = 13'sd1000;
        yin = -13'sd1000;
        aux = 1'b1;
        repeat (8 * 3 + 5) tick();
        reset_n = 1'b0;
        tick();
        check_eq("rst_x", xout, 0);
        check_eq("rst_aux", aux_out, 0);
        reset_n = 1'b1;
        stb_q.delete();
        repeat (8 * 5 + 6) tick();
        check_eq("rst_first_latency", stb_q.size() > 0 ? stb_q[0] - rst_cyc : -1, 13);
        check_eq("rst_dc_x", xout, 1000);
        check_eq("rst_dc_y", yout, -1000);

        // R=1 full throughput with random data
        do_reset(1, 2);
        aux = 1'b1;
        for (int i = 0; i < 40; i++) begin
            xin = IW'($urandom);
            yin = IW'($urandom);
            tick();
        end
        check_eq("r1_nstb", stb_q.size(), 40 - 5);

        // Fully random: data, strobes, enables, rate/shift changes, resets
        do_reset(5, 7);
        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom % 700) != 0;
            ce = ($urandom % 8) != 0;
            aux = ($urandom % 10) < 7;
            xin = IW'($urandom);
            yin = IW'($urandom);
            if ($urandom % 40 == 0) begin
                rate = RW'($urandom_range(0, 12));
                shift = SW'($urandom_range(0, 20));
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
